// File: rtl/key_step_ctrl_if.sv
// key_step_ctrl_if: debounced key and halt in; CPU enable, mode and press status out
interface key_step_ctrl_if #(
  parameter int CNT_W = 16
);
  logic key_level;
  logic halt;
  logic cpu_ce;
  logic run_mode;
  logic press_short;
  logic press_long;
  logic [CNT_W-1:0] step_cnt;
  modport master (
    output key_level, halt,
    input  cpu_ce, run_mode, press_short, press_long, step_cnt
  );
  modport slave (
    input  key_level, halt,
    output cpu_ce, run_mode, press_short, press_long, step_cnt
  );
endinterface

// File: rtl/key_step_ctrl.sv
// key_step_ctrl: single-step / free-run CPU clock-enable controller fed by a debounced key
// KEY_STEP_SAT_EN defined: step_cnt saturates at all-ones; undefined: step_cnt wraps.
module key_step_ctrl #(
  parameter int LONG_CNT = 50_000_000,
  parameter int RUN_DIV  = 1,
  parameter int CNT_W    = 16
) (
  input logic clk,
  input logic rst,
  key_step_ctrl_if.slave bus
);
  localparam int HW = $clog2(LONG_CNT);
  localparam int DW = RUN_DIV > 1 ? $clog2(RUN_DIV) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CNT - 1);
  localparam logic [DW-1:0] DIV_MAX  = DW'(RUN_DIV - 1);
  typedef enum logic [1:0] {IDLE, PRESS, HELD} state_t;
  state_t state, state_nxt;
  logic key_d, rise, fall;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [DW-1:0] div_cnt;
  logic short_nxt, long_nxt, run_nxt, run_ce, ce_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  assign rise = bus.key_level & ~key_d;
  assign fall = ~bus.key_level & key_d;
  assign run_ce = bus.run_mode & ~bus.halt & (div_cnt == DIV_MAX);
  assign ce_nxt = (short_nxt & ~bus.run_mode) | run_ce;
  assign run_nxt = ~bus.halt & (bus.run_mode ^ long_nxt);
`ifdef KEY_STEP_SAT_EN
  assign cnt_nxt = &bus.step_cnt ? bus.step_cnt : bus.step_cnt + 1'b1;
`else
  assign cnt_nxt = bus.step_cnt + 1'b1;
`endif
  // press classifier state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  // classify a press as short or long while tracking how long the key is held
  always_comb begin
    state_nxt = state;
    hold_nxt = hold_cnt;
    short_nxt = 1'b0;
    long_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = PRESS;
          hold_nxt = '0;
        end
      end
      PRESS: begin
        if (bus.key_level && hold_cnt == HOLD_MAX) begin
          state_nxt = HELD;
          long_nxt = 1'b1;
        end else if (fall) begin
          state_nxt = IDLE;
          short_nxt = 1'b1;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      HELD: state_nxt = fall ? IDLE : HELD;
      default: state_nxt = IDLE;
    endcase
  end
  // registered pulses, mode, run divider and cpu_ce bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      key_d <= 1'b1;
      hold_cnt <= '0;
      div_cnt <= '0;
      bus.cpu_ce <= 1'b0;
      bus.run_mode <= 1'b0;
      bus.press_short <= 1'b0;
      bus.press_long <= 1'b0;
      bus.step_cnt <= '0;
    end else begin
      key_d <= bus.key_level;
      hold_cnt <= hold_nxt;
      div_cnt <= (!bus.run_mode || div_cnt == DIV_MAX) ? '0 : div_cnt + 1'b1;
      bus.cpu_ce <= ce_nxt;
      bus.run_mode <= run_nxt;
      bus.press_short <= short_nxt;
      bus.press_long <= long_nxt;
      if (bus.cpu_ce) bus.step_cnt <= cnt_nxt;
    end
  end
endmodule
